// File: rtl/wos_kernel_if.sv
// ---------------------------------------------------------------------------
// wos_kernel_if
// Pixel stream, configuration and result bundle of the weighted order
// statistics compute stage.
//
// Handshake: pix_valid, newline, start and cfg_we are single-cycle strobes
// sampled on the rising clock edge; there is no back-pressure. busy is high
// while a compute runs (start is ignored then). out_valid is a one-cycle
// pulse, and out_pixel holds the result until the next pulse.
//
// Signals:
//   pix_valid/pix_data/pix_pad  pixel strobe, value, out-of-bounds flag
//   newline                     clear all window valid flags
//   start                       snapshot the window and begin computing
//   cfg_we/cfg_addr/cfg_data    weight (addr < MAX_N) or threshold (addr == MAX_N)
//   busy/out_valid/out_pixel    compute status and result
//   dbg_state                   FSM state (0 IDLE, 1 SCAN, 2 DONE)
// Modports: master drives the stream, slave is the kernel.
// ---------------------------------------------------------------------------
interface wos_kernel_if #(
   parameter int WORD  = 8,
   parameter int SUM_W = 9
);
   logic             pix_valid;
   logic [WORD-1:0]  pix_data;
   logic             pix_pad;
   logic             newline;
   logic             start;
   logic             cfg_we;
   logic [4:0]       cfg_addr;
   logic [SUM_W-1:0] cfg_data;
   logic             busy;
   logic             out_valid;
   logic [WORD-1:0]  out_pixel;
   logic [1:0]       dbg_state;

   modport master (
      output pix_valid, pix_data, pix_pad, newline, start,
      output cfg_we, cfg_addr, cfg_data,
      input  busy, out_valid, out_pixel, dbg_state
   );

   modport slave (
      input  pix_valid, pix_data, pix_pad, newline, start,
      input  cfg_we, cfg_addr, cfg_data,
      output busy, out_valid, out_pixel, dbg_state
   );
endinterface

// File: rtl/wos_kernel.sv
// ---------------------------------------------------------------------------
// wos_kernel
// Weighted order statistics compute stage. Keeps the last MAX_N pixels as
// the active window (slot 0 newest). On start it snapshots window, valid
// flags, weights and threshold, then resolves the result MSB first by
// threshold decomposition, one bit per cycle: a candidate bit is kept when
// the weight of valid slots >= candidate reaches the threshold.
//
// Ports:
//   clk  clock
//   rst  asynchronous, active-low reset
//   bus  wos_kernel_if.slave (pixel stream, config, result, dbg_state)
//
// Optional feature, macro WOS_ADAPT_THR_EN: a stored threshold of 0 is
// replaced at start by ceil(V/2), V = total weight of valid slots (1 if
// V = 0). Without the macro threshold 0 is used literally.
// ---------------------------------------------------------------------------
module wos_kernel #(
   parameter int WORD  = 8,
   parameter int MAX_N = 25,
   parameter int WW    = 4
) (
   input logic       clk,
   input logic       rst,
   wos_kernel_if.slave bus
);
   localparam int SUM_W = WW + $clog2(MAX_N + 1);
   localparam int BW    = (WORD > 1) ? $clog2(WORD) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // live window and configuration
   logic [WORD-1:0]  slot_q [MAX_N];
   logic [WORD-1:0]  slot_d [MAX_N];
   logic [MAX_N-1:0] valid_q, valid_d;
   logic [WW-1:0]    w_q [MAX_N];
   logic [WW-1:0]    w_d [MAX_N];
   logic [SUM_W-1:0] thr_q, thr_d;

   // snapshot used by the compute
   logic [WORD-1:0]  snap_slot_q [MAX_N];
   logic [MAX_N-1:0] snap_valid_q;
   logic [WW-1:0]    snap_w_q [MAX_N];
   logic [SUM_W-1:0] snap_thr_q;

   logic [WORD-1:0]  res_q, res_d;
   logic [BW-1:0]    bit_q;
   logic [WORD-1:0]  out_pixel_q;

   logic [WORD-1:0]  cand;
   logic [SUM_W-1:0] s_sum;
   logic [SUM_W-1:0] eff_thr;
   logic             take_start;

   assign take_start = (state_q == IDLE) && bus.start;

   // ---------------- window update ----------------
   always_comb begin
      slot_d  = slot_q;
      valid_d = valid_q;
      // newline clears first so a same-cycle pixel still lands as valid
      if (bus.newline) valid_d = '0;
      if (bus.pix_valid) begin
         for (int i = MAX_N - 1; i >= 1; i--) begin
            slot_d[i]  = slot_q[i-1];
            valid_d[i] = valid_d[i-1];
         end
         slot_d[0]  = bus.pix_data;
         valid_d[0] = ~bus.pix_pad;
      end
   end

   // ---------------- configuration ----------------
   always_comb begin
      w_d   = w_q;
      thr_d = thr_q;
      if (bus.cfg_we) begin
         if (int'(bus.cfg_addr) < MAX_N)
            w_d[bus.cfg_addr] = bus.cfg_data[WW-1:0];
         else if (int'(bus.cfg_addr) == MAX_N)
            thr_d = bus.cfg_data;
      end
   end

   // ---------------- threshold captured at start ----------------
`ifdef WOS_ADAPT_THR_EN
   logic [SUM_W-1:0] v_sum;
   logic [SUM_W:0]   v_plus1;

   always_comb begin
      v_sum = '0;
      for (int i = 0; i < MAX_N; i++)
         if (valid_q[i]) v_sum = v_sum + SUM_W'(w_q[i]);
      v_plus1 = {1'b0, v_sum} + {{SUM_W{1'b0}}, 1'b1};
      if (thr_q != '0)
         eff_thr = thr_q;
      else if (v_sum == '0)
         eff_thr = SUM_W'(1);
      else
         eff_thr = v_plus1[SUM_W:1];   // ceil(V/2)
   end
`else
   assign eff_thr = thr_q;
`endif

   // ---------------- bit decision ----------------
   always_comb begin
      cand  = res_q | (WORD'(1) << bit_q);
      s_sum = '0;
      for (int i = 0; i < MAX_N; i++)
         if (snap_valid_q[i] && (snap_slot_q[i] >= cand))
            s_sum = s_sum + SUM_W'(snap_w_q[i]);
      res_d = (s_sum >= snap_thr_q) ? cand : res_q;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = SCAN;
         SCAN:    if (bit_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.busy      = (state_q == SCAN);
      bus.out_valid = (state_q == DONE);
      bus.dbg_state = state_q;
      bus.out_pixel = out_pixel_q;
   end

   // ---------------- live state registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAX_N; i++) begin
            slot_q[i] <= '0;
            w_q[i]    <= WW'(1);
         end
         valid_q <= '0;
         thr_q   <= SUM_W'((MAX_N + 1) / 2);
      end else begin
         slot_q  <= slot_d;
         valid_q <= valid_d;
         w_q     <= w_d;
         thr_q   <= thr_d;
      end
   end

   // ---------------- compute registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAX_N; i++) begin
            snap_slot_q[i] <= '0;
            snap_w_q[i]    <= '0;
         end
         snap_valid_q <= '0;
         snap_thr_q   <= '0;
         res_q        <= '0;
         bit_q        <= '0;
         out_pixel_q  <= '0;
      end else begin
         if (take_start) begin
            snap_slot_q  <= slot_q;
            snap_valid_q <= valid_q;
            snap_w_q     <= w_q;
            snap_thr_q   <= eff_thr;
            res_q        <= '0;
            bit_q        <= BW'(WORD - 1);
         end else if (state_q == SCAN) begin
            res_q <= res_d;
            if (bit_q != '0)
               bit_q <= bit_q - BW'(1);
            else
               // final bit resolved: result is visible during DONE alongside out_valid
               out_pixel_q <= res_d;
         end
      end
   end
endmodule

// File: tb/tb_wos_kernel.sv
module tb_wos_kernel;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wos_kernel_if #(.WORD(8), .SUM_W(9)) bus ();

   wos_kernel #(.WORD(8), .MAX_N(25), .WW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor: every out_valid pops one expected result
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got pulse with %0d expected none", bus.out_pixel);
         end else begin
            mon_exp = exp_q.pop_front();
            check("out_pixel", 32'(bus.out_pixel), 32'(mon_exp));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle_in(input logic pv, input logic [7:0] pd, input logic pp,
                           input logic nl, input logic st, input logic we,
                           input logic [4:0] a, input logic [8:0] d);
      @(posedge clk);
      #1;
      bus.pix_valid = pv;
      bus.pix_data  = pd;
      bus.pix_pad   = pp;
      bus.newline   = nl;
      bus.start     = st;
      bus.cfg_we    = we;
      bus.cfg_addr  = a;
      bus.cfg_data  = d;
   endtask

   task automatic idle();
      cycle_in(0, 8'd0, 0, 0, 0, 0, 5'd0, 9'd0);
   endtask

   task automatic shift(input logic [7:0] pd, input logic pp);
      cycle_in(1, pd, pp, 0, 0, 0, 5'd0, 9'd0);
   endtask

   task automatic newline();
      cycle_in(0, 8'd0, 0, 1, 0, 0, 5'd0, 9'd0);
   endtask

   task automatic cfg(input logic [4:0] a, input logic [8:0] d);
      cycle_in(0, 8'd0, 0, 0, 0, 1, a, d);
   endtask

   task automatic wait_result(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL timeout_%s: got %0d pending results expected 0", name, exp_q.size());
         exp_q.delete();
      end
      idle();
   endtask

   task automatic run(input string name, input logic [7:0] exp);
      exp_q.push_back(exp);
      cycle_in(0, 8'd0, 0, 0, 1, 0, 5'd0, 9'd0);
      wait_result(name);
   endtask

   int busy_cnt, first_busy, ov_cyc;

   initial begin
      rst = 1'b0;
      bus.pix_valid = 0; bus.pix_data = 0; bus.pix_pad = 0; bus.newline = 0;
      bus.start = 0; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
      #12;
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_pixel", 32'(bus.out_pixel), 0);
      check("rst_state", 32'(bus.dbg_state), 0);
      #10 rst = 1'b1;

      // median at reset defaults, with latency profile
      newline();
      for (int i = 1; i <= 25; i++) shift(8'(i), 0);
      exp_q.push_back(8'd13);
      cycle_in(0, 8'd0, 0, 0, 1, 0, 5'd0, 9'd0);
      busy_cnt = 0; first_busy = -1; ov_cyc = -1;
      for (int c = 1; c <= 12; c++) begin
         idle();
         @(negedge clk);
         if (bus.busy) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = c;
         end
         if (bus.out_valid && ov_cyc < 0) ov_cyc = c;
      end
      check("busy_cycles", 32'(busy_cnt), 8);
      check("busy_first", 32'(first_busy), 1);
      check("out_valid_cycle", 32'(ov_cyc), 9);
      wait_result("median");
      check("out_pixel_hold", 32'(bus.out_pixel), 13);

      // weighted max / min / weighted slot
      cfg(5'd25, 9'd1);
      for (int i = 0; i < 25; i++)
         shift((i == 12) ? 8'd200 : (i == 20) ? 8'd4 : 8'(100 + i), 0);
      run("max", 8'd200);
      cfg(5'd25, 9'd25);
      run("min", 8'd4);
      cfg(5'd0, 9'd12);
      cfg(5'd25, 9'd13);
      run("weighted", 8'd124);
      cfg(5'd0, 9'd1);

      // pads and newline
      for (int i = 0; i < 25; i++) shift(8'd50, 0);
      newline();
      for (int i = 0; i < 10; i++) shift(8'd90, 0);
      for (int i = 0; i < 15; i++) shift(8'd238, 1);
      cfg(5'd25, 9'd5);
      run("pads_thr5", 8'd90);
      cfg(5'd25, 9'd11);
      run("pads_thr11", 8'd0);

      // newline and pixel in the same cycle
      for (int i = 0; i < 24; i++) shift(8'd60, 0);
      cycle_in(1, 8'd70, 0, 1, 0, 0, 5'd0, 9'd0);
      cfg(5'd25, 9'd1);
      run("nl_pix_thr1", 8'd70);
      cfg(5'd25, 9'd2);
      run("nl_pix_thr2", 8'd0);

      // no valid slots
      newline();
      cfg(5'd25, 9'd1);
      run("no_valid", 8'd0);

      // threshold 0
      cfg(5'd25, 9'd0);
      newline();
      for (int i = 1; i <= 9; i++) shift(8'(10 * i), 0);
      for (int i = 0; i < 16; i++) shift(8'd200, 1);
`ifdef WOS_ADAPT_THR_EN
      run("thr0", 8'd50);
`else
      run("thr0", 8'd255);
`endif

      // snapshot and ignored start
      cfg(5'd25, 9'd13);
      for (int i = 0; i < 25; i++) shift(8'd20, 0);
      exp_q.push_back(8'd20);
      cycle_in(0, 8'd0, 0, 0, 1, 0, 5'd0, 9'd0);
      shift(8'd255, 0);
      shift(8'd255, 0);
      cycle_in(1, 8'd255, 0, 0, 1, 0, 5'd0, 9'd0);
      shift(8'd255, 0);
      shift(8'd255, 0);
      cfg(5'd25, 9'd1);
      wait_result("snapshot");
      for (int i = 0; i < 12; i++) idle();
      run("after_snapshot", 8'd255);

      // async reset mid-SCAN
      cfg(5'd25, 9'd3);
      cfg(5'd5, 9'd9);
      cycle_in(0, 8'd0, 0, 0, 1, 0, 5'd0, 9'd0);
      for (int i = 0; i < 4; i++) idle();
      #3;
      check("midscan_busy", 32'(bus.busy), 1);
      rst = 1'b0;
      #1;
      check("arst_busy", 32'(bus.busy), 0);
      check("arst_out_valid", 32'(bus.out_valid), 0);
      check("arst_out_pixel", 32'(bus.out_pixel), 0);
      check("arst_state", 32'(bus.dbg_state), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 12; i++) idle();
      newline();
      for (int i = 1; i <= 25; i++) shift(8'(i), 0);
      run("defaults_after_reset", 8'd13);

      for (int i = 0; i < 4; i++) idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wos_kernel.md
Name: wos_kernel

Overview:
- Weighted order statistics (WOS) compute stage. It sits directly downstream of the filter address generator.
- It accepts the pixel stream read from memory, one pixel per strobe, column by column, with out-of-image positions flagged as pads.
- It keeps the last MAX_N pixels as the active window.
- On request it computes the WOS output by bitwise threshold decomposition, one bit per cycle, and presents the result for write-back.

Parameters:
- WORD, 8, pixel width in bits; pixels are unsigned.
- MAX_N, 25, number of window slots (n*n, n up to 5).
- WW, 4, weight width in bits; weights are unsigned.
- Derived: SUM_W = WW + $clog2(MAX_N+1), which is 9 at the defaults.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- pix_valid  in  1  pixel strobe; shift one pixel into the window
- pix_data  in  WORD  pixel value
- pix_pad  in  1  with pix_valid: slot is out-of-bounds and contributes weight 0
- newline  in  1  clear all slot valid flags (start of a new kernel row)
- start  in  1  pulse: snapshot the window and begin computing
- cfg_we  in  1  weight/threshold write strobe
- cfg_addr  in  5  0..MAX_N-1 selects a weight; MAX_N selects the threshold
- cfg_data  in  SUM_W  weight (low WW bits used) or threshold
- busy  out  1  compute in progress
- out_valid  out  1  one-cycle pulse; result valid
- out_pixel  out  WORD  WOS result, held until the next out_valid

Behaviour:
- Reset, async on rst low:
  - All outputs are 0, state is IDLE.
  - All slot data and valid flags are 0.
  - All weights are 1 and the threshold is (MAX_N+1)/2, i.e. the default is a median.
- Window:
  - Slot 0 is the newest pixel.
  - On pix_valid, slot[i] <= slot[i-1] for i from MAX_N-1 down to 1; slot[0] <= pix_data; valid[0] <= ~pix_pad.
  - On newline, all valid flags are cleared.
  - If newline and pix_valid occur in the same cycle, newline applies first; the incoming pixel is then shifted in with valid = ~pix_pad.
  - Window updates continue while busy; the compute uses only the snapshot.
- Config:
  - cfg_we writes take effect on the next edge.
  - cfg_addr > MAX_N is ignored.
  - Writes while busy affect the next start only; the snapshot includes the weights and the threshold.
- States:
  - IDLE, on start: snapshot the window, valid flags, weights and threshold; set res = 0, b = WORD-1; go to SCAN; busy = 1.
  - SCAN, each cycle:
    - cand = res | (1<<b).
    - S = sum of w[i] over i with valid[i] and slot[i] >= cand. S is computed combinationally at full SUM_W width and never overflows.
    - If S >= thr, res <= cand.
    - If b == 0, go to DONE; otherwise b <= b-1.
  - DONE, one cycle: out_pixel <= res; out_valid = 1; busy = 0; go to IDLE.
- Latency: start to out_valid is WORD+1 cycles, i.e. 9 at the defaults. Throughput is one result per WORD+2 cycles.
- start while busy is ignored: no restart and no queue.
- Threshold 0: every candidate passes, so the result is 2^WORD-1.
- No valid slots with threshold > 0: the result is 0.
- Threshold greater than the total valid weight: the result is 0.
- rst low mid-compute aborts immediately to the reset state; out_valid is not pulsed.

Optional Feature:
- Macro: WOS_ADAPT_THR_EN.
- With the macro defined: when the stored threshold is 0, the effective threshold captured at start is ceil(V/2). V is the sum of the weights of the valid slots, counting only weights that are non-zero. This gives a weighted median over the in-bounds region only, for image borders.
- Without the macro: threshold 0 is used literally, giving the result 2^WORD-1.
- V is computed at SUM_W width. If V = 0, the effective threshold is 1.

Test Plan:
- Median at reset defaults: reset; newline; shift pixels 1..25 all non-pad; start -> after 9 cycles out_valid=1, out_pixel=13, busy high exactly cycles 1-8.
- Weighted max: set thr=1, all weights 1; shift 25 pixels with a maximum of 200 -> out_pixel=200. Set thr=25 -> out_pixel equals the minimum pixel.
- Pads and newline: shift 25 pixels of 50, then newline, then 10 pixels of 90 (non-pad) and 15 pads; thr=5 -> 90. thr=11 -> 0.
- Snapshot and ignore: start, then shift 5 pixels of 255 and pulse start again at cycle 3 -> a single out_valid with the result of the old window. The next start uses the new window.
- Async reset mid-SCAN: assert rst at cycle 4 -> busy=0 and out_pixel=0 immediately, no out_valid pulse. Weights and threshold return to their defaults.
- WOS_ADAPT_THR_EN: thr=0; newline; 9 valid pixels 10..90 and 16 pads; start -> out_pixel=50. Without the macro -> 255.
